// File: rtl/detection_sequencer.sv
// Sequences a bank of Haar classifiers over one shared integral-image read port
// and reduces their per-classifier hits to a vote-based face decision.
module detection_sequencer #(
    parameter int NUM_CLS        = 4,
    parameter int ADDR_W         = 15,
    parameter int MIN_VOTES      = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        frame_ready,
    input  logic [NUM_CLS*ADDR_W-1:0]   cls_rd_addr,
    input  logic [NUM_CLS-1:0]          cls_done,
    input  logic [NUM_CLS-1:0]          cls_flag,
    output logic [NUM_CLS-1:0]          cls_en,
    output logic [ADDR_W-1:0]           buf_rd_addr,
    output logic                        busy,
    output logic                        result_valid,
    output logic [NUM_CLS-1:0]          result_vec,
    output logic [$clog2(NUM_CLS+1)-1:0] hit_count,
    output logic                        face_detected,
    output logic                        timeout_err,
    output logic                        frame_dropped
);
    localparam int IDX_W = (NUM_CLS > 1) ? $clog2(NUM_CLS) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HC_W  = $clog2(NUM_CLS + 1);

    typedef enum logic [2:0] {IDLE, START, WAIT, NEXT, REPORT} state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [TMR_W-1:0]   timer, timer_n;
    logic [NUM_CLS-1:0] acc, acc_n, en_n, rvec_n;
    logic [HC_W-1:0]    hc_n, acc_pop;
    logic               tmo_n, fd_n, rv_n, busy_n, drop_n;

    always_comb begin
        acc_pop = '0;
        for (int i = 0; i < NUM_CLS; i++)
            acc_pop = acc_pop + HC_W'(acc[i]);
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        timer_n = timer;
        acc_n   = acc;
        en_n    = cls_en;
        tmo_n   = timeout_err;
        rvec_n  = result_vec;
        hc_n    = hit_count;
        fd_n    = face_detected;
        rv_n    = 1'b0;
        drop_n  = frame_ready && (state != IDLE);
        case (state)
            IDLE: begin
                if (frame_ready) begin
                    idx_n   = '0;
                    acc_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                en_n      = '0;
                en_n[idx] = 1'b1;
                timer_n   = '0;
                state_n   = WAIT;
            end
            WAIT: begin
                // Timer saturates so a stuck classifier can never wrap it back past the limit.
                if (timer != TMR_W'(TIMEOUT_CYCLES))
                    timer_n = timer + TMR_W'(1);
                if (cls_done[idx]) begin
                    acc_n[idx] = cls_flag[idx];
                    en_n       = '0;
                    state_n    = NEXT;
                end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    acc_n[idx] = 1'b0;
                    tmo_n      = 1'b1;
                    en_n       = '0;
                    state_n    = NEXT;
                end
            end
            NEXT: begin
                if (idx == IDX_W'(NUM_CLS - 1)) begin
                    state_n = REPORT;
                end else begin
                    idx_n   = idx + IDX_W'(1);
                    state_n = START;
                end
            end
            REPORT: begin
                rvec_n  = acc;
                hc_n    = acc_pop;
                fd_n    = (acc_pop >= HC_W'(MIN_VOTES));
                rv_n    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    // Zero-latency steering keeps the classifier's own address-to-data timing intact.
    always_comb begin
        buf_rd_addr = '0;
        if (state == START || state == WAIT) begin
            for (int k = 0; k < NUM_CLS; k++)
                if (idx == IDX_W'(k))
                    buf_rd_addr = cls_rd_addr[k*ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            timer         <= '0;
            acc           <= '0;
            cls_en        <= '0;
            busy          <= 1'b0;
            result_valid  <= 1'b0;
            result_vec    <= '0;
            hit_count     <= '0;
            face_detected <= 1'b0;
            timeout_err   <= 1'b0;
            frame_dropped <= 1'b0;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            timer         <= timer_n;
            acc           <= acc_n;
            cls_en        <= en_n;
            busy          <= busy_n;
            result_valid  <= rv_n;
            result_vec    <= rvec_n;
            hit_count     <= hc_n;
            face_detected <= fd_n;
            timeout_err   <= tmo_n;
            frame_dropped <= drop_n;
        end
    end
endmodule

// File: tb/tb_detection_sequencer.sv
// Randomized bench: behavioural classifier models plus a per-pass reference of the
// expected vote outcome, enable ordering, enable durations and address steering.
module tb_detection_sequencer;
    localparam int NUM_CLS = 4, ADDR_W = 15, MIN_VOTES = 3, TMO = 64;
    localparam int HC_W = $clog2(NUM_CLS + 1);

    logic clk = 1'b0, rst_n = 1'b0, frame_ready = 1'b0;
    logic [NUM_CLS*ADDR_W-1:0] cls_rd_addr = '0;
    logic [NUM_CLS-1:0] cls_done = '0, cls_flag = '0, cls_en, result_vec;
    logic [ADDR_W-1:0] buf_rd_addr;
    logic [HC_W-1:0] hit_count;
    logic busy, result_valid, face_detected, timeout_err, frame_dropped;

    int total = 0, bad = 0;
    int lat[NUM_CLS];
    bit flagv[NUM_CLS];
    int cnt[NUM_CLS];
    bit stray_en = 0, stray3 = 0, steer = 0, exp_tmo = 0;
    logic [NUM_CLS-1:0] prev_en = '0;
    int low_cnt = 100, hlen = 0;
    int addr_err = 0, onehot_err = 0, gap_err = 0, drop_err = 0, rv_cnt = 0, dp_cnt = 0;
    int order_q[$], len_q[$];
    logic fr_s = 1'b0, busy_s = 1'b0, rst_s = 1'b0;

    always #5 clk = ~clk;

    detection_sequencer #(.NUM_CLS(NUM_CLS), .ADDR_W(ADDR_W), .MIN_VOTES(MIN_VOTES),
                          .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .frame_ready(frame_ready), .cls_rd_addr(cls_rd_addr),
        .cls_done(cls_done), .cls_flag(cls_flag), .cls_en(cls_en), .buf_rd_addr(buf_rd_addr),
        .busy(busy), .result_valid(result_valid), .result_vec(result_vec),
        .hit_count(hit_count), .face_detected(face_detected), .timeout_err(timeout_err),
        .frame_dropped(frame_dropped));

    // Inputs as the DUT sees them at the edge, for the dropped-frame expectation.
    always @(posedge clk) begin
        fr_s   <= frame_ready;
        busy_s <= busy;
        rst_s  <= rst_n;
    end

    // Classifier models: done L cycles after enable rises; monitors enable shape and steering.
    always @(negedge clk) begin : model
        logic [ADDR_W-1:0] ea;
        logic [NUM_CLS-1:0] d, f;
        int sk;
        ea = '0;
        for (int k = 0; k < NUM_CLS; k++)
            if (cls_en[k]) ea = cls_rd_addr[k*ADDR_W +: ADDR_W];
        if ((cls_en != 0 || busy === 1'b0) && buf_rd_addr !== ea) addr_err++;
        if ($countones(cls_en) > 1) onehot_err++;
        if (frame_dropped !== (fr_s && busy_s && rst_s)) drop_err++;
        if (result_valid === 1'b1) rv_cnt++;
        if (frame_dropped === 1'b1) dp_cnt++;
        if (prev_en != 0 && cls_en == 0) len_q.push_back(hlen);
        for (int k = 0; k < NUM_CLS; k++)
            if (cls_en[k] && !prev_en[k]) begin
                order_q.push_back(k);
                if (low_cnt < 2) gap_err++;
                cnt[k] = 0;
            end
        if (cls_en == 0) begin low_cnt++; hlen = 0; end
        else begin low_cnt = 0; hlen++; end
        d = '0;
        for (int k = 0; k < NUM_CLS; k++) begin
            if (cls_en[k]) cnt[k]++;
            d[k] = cls_en[k] && lat[k] != 0 && cnt[k] == lat[k];
            f[k] = d[k] ? flagv[k] : 1'($urandom);
        end
        if (stray3 && cls_en[0]) begin d[3] = 1'b1; f[3] = 1'b1; end
        if (stray_en && $urandom_range(0, 3) == 0) begin
            sk = $urandom_range(0, NUM_CLS - 1);
            if (!cls_en[sk]) begin d[sk] = 1'b1; f[sk] = 1'b1; end
        end
        cls_done = d;
        cls_flag = f;
        for (int k = 0; k < NUM_CLS; k++)
            cls_rd_addr[k*ADDR_W +: ADDR_W] = steer ? ((k == 2) ? 15'h1234 : 15'h7FFF)
                                                     : ADDR_W'($urandom);
        prev_en = cls_en;
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // One full pass with inline checks against the reference outcome.
    task automatic run_pass(input int drop_at, input string nm);
        logic [NUM_CLS-1:0] ev;
        int hits, oerr, lerr, el;
        bit got;
        ev = '0;
        for (int k = 0; k < NUM_CLS; k++)
            if (lat[k] >= 1 && lat[k] <= TMO) ev[k] = flagv[k];
            else exp_tmo = 1;
        hits = $countones(ev);
        order_q.delete(); len_q.delete();
        rv_cnt = 0; dp_cnt = 0; addr_err = 0; onehot_err = 0; gap_err = 0; drop_err = 0;
        tick; frame_ready = 1'b1;
        tick; frame_ready = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_start got=%b exp=1", nm, busy); end
        got = 0;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            if (cyc == drop_at) frame_ready = 1'b1;
            tick;
            frame_ready = 1'b0;
            if (result_valid === 1'b1) begin got = 1; break; end
        end
        total++;
        if (!got) begin bad++; $display("FAIL %s result_valid_wait got=timeout exp=pulse", nm); end
        total++;
        if (result_vec !== ev) begin bad++; $display("FAIL %s result_vec got=%b exp=%b", nm, result_vec, ev); end
        total++;
        if (hit_count !== HC_W'(hits)) begin bad++; $display("FAIL %s hit_count got=%0d exp=%0d", nm, hit_count, hits); end
        total++;
        if (face_detected !== (hits >= MIN_VOTES)) begin
            bad++; $display("FAIL %s face_detected got=%b exp=%b", nm, face_detected, hits >= MIN_VOTES);
        end
        total++;
        if (timeout_err !== exp_tmo) begin bad++; $display("FAIL %s timeout_err got=%b exp=%b", nm, timeout_err, exp_tmo); end
        oerr = (order_q.size() == NUM_CLS) ? 0 : 100;
        lerr = (len_q.size() == NUM_CLS) ? 0 : 100;
        for (int i = 0; i < NUM_CLS; i++) begin
            if (i < order_q.size() && order_q[i] != i) oerr++;
            el = (lat[i] == 0 || lat[i] > TMO) ? TMO : lat[i];
            if (i < len_q.size() && len_q[i] != el) lerr++;
        end
        total++;
        if (oerr !== 0) begin bad++; $display("FAIL %s en_order got=%0d bad entries of %0d exp=0", nm, oerr, order_q.size()); end
        total++;
        if (lerr !== 0) begin bad++; $display("FAIL %s en_duration got=%0d bad entries exp=0", nm, lerr); end
        total++;
        if ({addr_err, onehot_err, gap_err} !== 96'd0) begin
            bad++; $display("FAIL %s en_shape addr=%0d onehot=%0d gap=%0d exp=0", nm, addr_err, onehot_err, gap_err);
        end
        total++;
        if (drop_err !== 0 || dp_cnt !== ((drop_at != 0) ? 1 : 0)) begin
            bad++; $display("FAIL %s frame_dropped errs=%0d pulses=%0d exp_pulses=%0d", nm, drop_err, dp_cnt, drop_at != 0);
        end
        tick;
        total++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || rv_cnt !== 1) begin
            bad++; $display("FAIL %s end_of_pass rv=%b busy=%b rv_pulses=%0d exp 0,0,1", nm, result_valid, busy, rv_cnt);
        end
    endtask

    task automatic set_pass(input int l0, l1, l2, l3, input bit f0, f1, f2, f3);
        lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
        flagv[0] = f0; flagv[1] = f1; flagv[2] = f2; flagv[3] = f3;
    endtask

    task automatic check_zero_outputs(input string nm);
        total++;
        if ({cls_en, busy, result_valid, result_vec, hit_count, face_detected, timeout_err,
             frame_dropped, buf_rd_addr} !== '0) begin
            bad++;
            $display("FAIL %s outputs_zero en=%b busy=%b rv=%b vec=%b hc=%0d fd=%b tmo=%b drop=%b addr=%h exp all 0",
                     nm, cls_en, busy, result_valid, result_vec, hit_count, face_detected,
                     timeout_err, frame_dropped, buf_rd_addr);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick;
        check_zero_outputs("reset_held");
        rst_n = 1'b1; exp_tmo = 0;
        repeat (2) tick;
        check_zero_outputs("reset_released");
    endtask

    task automatic test_full_pass;
        set_pass(12, 12, 12, 12, 1, 0, 1, 1);
        run_pass(0, "full_pass");
    endtask

    task automatic test_addr_steer;
        bit seen;
        set_pass(12, 12, 12, 12, 0, 1, 1, 0);
        steer = 1;
        seen = 0;
        fork
            run_pass(0, "addr_steer");
            begin
                for (int i = 0; i < 500 && !seen; i++) begin
                    tick;
                    if (cls_en[2] === 1'b1) seen = 1;
                end
                total++;
                if (!seen || buf_rd_addr !== 15'h1234) begin
                    bad++; $display("FAIL addr_steer cls2_addr got=%h seen=%b exp=1234", buf_rd_addr, seen);
                end
            end
        join
        steer = 0;
        tick;
        total++;
        if (buf_rd_addr !== '0) begin bad++; $display("FAIL addr_steer idle_addr got=%h exp=0", buf_rd_addr); end
    endtask

    task automatic test_vote_boundary;
        set_pass(12, 12, 12, 12, 1, 1, 0, 0);
        run_pass(0, "vote_2");
        set_pass(12, 12, 12, 12, 1, 1, 1, 0);
        stray3 = 1;
        run_pass(0, "vote_3_stray");
        stray3 = 0;
    endtask

    task automatic test_timeout;
        set_pass(12, 64, 12, 12, 1, 1, 1, 1);
        run_pass(0, "done_at_limit");
        set_pass(12, 0, 12, 12, 1, 1, 1, 1);
        run_pass(0, "timeout");
        set_pass(5, 7, 9, 11, 1, 0, 0, 1);
        run_pass(0, "timeout_sticky");
    endtask

    task automatic test_reset_mid_pass;
        bit seen;
        set_pass(3, 40, 12, 12, 1, 1, 1, 1);
        tick; frame_ready = 1'b1;
        tick; frame_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick;
            if (cls_en[1] === 1'b1) seen = 1;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL reset_mid en1_wait got=timeout exp=cls_en[1]"); end
        repeat (4) tick;
        rst_n = 1'b0;
        tick;
        check_zero_outputs("reset_mid_pass");
        rst_n = 1'b1; exp_tmo = 0;
        tick;
        check_zero_outputs("reset_mid_after");
    endtask

    task automatic test_overlap;
        set_pass(12, 12, 12, 12, 1, 0, 1, 1);
        run_pass(6, "overlap_drop");
        set_pass(10, 11, 12, 13, 0, 1, 1, 1);
        run_pass(0, "overlap_next");
    endtask

    task automatic test_random;
        int r;
        stray_en = 1;
        for (int p = 0; p < 10; p++) begin
            for (int k = 0; k < NUM_CLS; k++) begin
                r = $urandom_range(0, 19);
                lat[k] = (r == 0) ? 0 : (r == 1) ? 65 : (r == 2) ? 64 : $urandom_range(1, 30);
                flagv[k] = 1'($urandom);
            end
            run_pass((p % 3 == 0) ? $urandom_range(2, 20) : 0, $sformatf("random_%0d", p));
        end
        stray_en = 0;
    endtask

    initial begin
        for (int k = 0; k < NUM_CLS; k++) begin lat[k] = 12; flagv[k] = 0; cnt[k] = 0; end
        test_reset;
        test_full_pass;
        test_addr_steer;
        test_vote_boundary;
        test_timeout;
        test_reset_mid_pass;
        test_overlap;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
